// File: rtl/booth_q_reg.sv
// Booth multiplier Q register with Q[-1] extension, radix-2/radix-4 shifting,
// Booth recoding triple and iteration status for the control unit.
module booth_q_reg #(
    parameter int WIDTH = 64,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             c0,
    input  logic             c4,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       shift_in,
    output logic [WIDTH-1:0] q,
    output logic             q_m1,
    output logic [2:0]       bcode,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             last,
    output logic             done
);

    localparam logic [CNT_W-1:0] N_R2 = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] N_R4 = CNT_W'(WIDTH / 2);

    logic             mode_r;
    logic [CNT_W-1:0] n_steps;

    assign n_steps = mode_r ? N_R4 : N_R2;
    assign last    = busy && (cnt == n_steps - 1'b1);

    // Radix-2 duplicates q[0] so both modes share one radix-4 decoder
    assign bcode = {mode_r ? q[1] : q[0], q[0], q_m1};

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            q      <= '0;
            q_m1   <= 1'b0;
            cnt    <= '0;
            mode_r <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else if (c0) begin
            q      <= din;
            q_m1   <= 1'b0;
            cnt    <= '0;
            mode_r <= mode;
            busy   <= 1'b1;
            done   <= 1'b0;
        end else if (c4 && busy) begin
            if (mode_r) begin
                q    <= {shift_in, q[WIDTH-1:2]};
                q_m1 <= q[1];
            end else begin
                q    <= {shift_in[0], q[WIDTH-1:1]};
                q_m1 <= q[0];
            end
            cnt  <= cnt + 1'b1;
            busy <= !last;
            done <= last;
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_booth_q_reg.sv
// Randomized and directed bench for booth_q_reg (WIDTH=8) against an
// arithmetic model of the A:Q:Q[-1] shift chain.
module tb_booth_q_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rst_b, c0, c4, mode;
    logic [W-1:0]  din;
    logic [1:0]    shift_in;
    logic [W-1:0]  q;
    logic          q_m1;
    logic [2:0]    bcode;
    logic [CW-1:0] cnt;
    logic          busy, last, done;

    booth_q_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst_b(rst_b), .c0(c0), .c4(c4), .mode(mode),
        .din(din), .shift_in(shift_in), .q(q), .q_m1(q_m1),
        .bcode(bcode), .cnt(cnt), .busy(busy), .last(last), .done(done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;
    int done_seen = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: Q is the low half of the pair {A[1:0], Q},
    // shifted right by one (radix-2) or two (radix-4) bits per step.
    logic [W-1:0] m_q;
    logic         m_qm1, m_mode, m_busy, m_done;
    int           m_cnt;

    function automatic int steps(input logic md);
        return md ? W / 2 : W;
    endfunction

    function automatic int digit(input logic [2:0] b);
        return -2 * int'(b[2]) + int'(b[1]) + int'(b[0]);
    endfunction

    always @(posedge clk) begin
        if (!rst_b) begin
            m_q <= '0; m_qm1 <= 1'b0; m_cnt <= 0;
            m_mode <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0;
        end else if (c0) begin
            m_q <= din; m_qm1 <= 1'b0; m_cnt <= 0;
            m_mode <= mode; m_busy <= 1'b1; m_done <= 1'b0;
        end else if (c4 && m_busy) begin
            m_q   <= W'({shift_in, m_q} >> (m_mode ? 2 : 1));
            m_qm1 <= m_q[m_mode ? 1 : 0];
            m_cnt <= m_cnt + 1;
            if (m_cnt + 1 == steps(m_mode)) begin
                m_busy <= 1'b0; m_done <= 1'b1;
            end else begin
                m_done <= 1'b0;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            int ed;
            chk("q", 32'(q), 32'(m_q));
            chk("q_m1", 32'(q_m1), 32'(m_qm1));
            chk("cnt", 32'(cnt), 32'(m_cnt));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("last", 32'(last),
                32'(m_busy && (m_cnt == steps(m_mode) - 1)));
            chk("bcode", 32'(bcode),
                32'({m_mode ? m_q[1] : m_q[0], m_q[0], m_qm1}));
            ed = m_mode ? digit({m_q[1], m_q[0], m_qm1})
                        : int'(m_qm1) - int'(m_q[0]);
            chk("bcode_digit", 32'(digit(bcode)), 32'(ed));
        end
    end

    always @(posedge clk) if (rst_b === 1'b1 && done === 1'b1) done_seen++;

    task automatic step(input logic r, input logic l, input logic s,
                        input logic md, input logic [W-1:0] d,
                        input logic [1:0] si);
        @(negedge clk);
        rst_b = r; c0 = l; c4 = s; mode = md; din = d; shift_in = si;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_b = 1'b0; c0 = 1'b0; c4 = 1'b0; mode = 1'b0;
        din = '0; shift_in = '0;

        // 1: reset wins over load
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 2'b00);
        cmp_en = 1'b1;
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_qm1", 32'(q_m1), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(cnt), 0);

        // 2: radix-2 load and one shift
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 2'b00);
        chk("r2_load_q", 32'(q), 32'hA5);
        chk("r2_load_bcode", 32'(bcode), 32'b110);
        chk("r2_load_busy", 32'(busy), 1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'b01);
        chk("r2_shift_q", 32'(q), 32'hD2);
        chk("r2_shift_qm1", 32'(q_m1), 1);
        chk("r2_shift_cnt", 32'(cnt), 1);

        // 3: radix-4 load and one shift
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h6C, 2'b00);
        chk("r4_load_bcode", 32'(bcode), 32'b000);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'b10);
        chk("r4_shift_q", 32'(q), 32'h9B);
        chk("r4_shift_qm1", 32'(q_m1), 0);
        chk("r4_shift_bcode", 32'(bcode), 32'b110);

        // 4: full radix-4 run, then an ignored extra shift
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 2'b00);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'b11);
        chk("r4_last", 32'(last), 1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'b11);
        chk("r4_end_busy", 32'(busy), 0);
        chk("r4_end_done", 32'(done), 1);
        chk("r4_end_cnt", 32'(cnt), 4);
        chk("r4_end_q", 32'(q), 32'hFF);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
        chk("r4_extra_q", 32'(q), 32'hFF);
        chk("r4_extra_done", 32'(done), 0);
        chk("r4_extra_cnt", 32'(cnt), 4);

        // 5: load beats shift while busy; mid-run reset has no done
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 2'b00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'b01);
        step(1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 2'b11);
        chk("ld_pri_q", 32'(q), 32'h3C);
        chk("ld_pri_cnt", 32'(cnt), 0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'b01);
        step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'b01);
        chk("abort_cnt_pre", 32'(cnt), 2);
        done_seen = 0;
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b01);
        chk("abort_q", 32'(q), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_cnt", 32'(cnt), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2'b11);
        chk("abort_no_done", 32'(done_seen), 0);

        // Random phase
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom), W'($urandom), 2'($urandom));
        end

        @(negedge clk);
        #1;
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
